// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states, byte width, parity helper.
// Used by the TX arbiter and by the transmitter for its parity bit.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    // Even parity: XOR of all data bits.
    function automatic logic parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports: i_req     - request vector
//        i_last_grant - index granted last time
//        o_winner  - first requester at or after i_last_grant+1 (wrapping)
//        o_any     - at least one request present
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any
);

    // Walk offsets from farthest to nearest so that the nearest
    // asserted request after last_grant is the final assignment.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (i_req[(int'(i_last_grant) + off) % NUM_REQ]) begin
                o_winner = IDX_W'((int'(i_last_grant) + off) % NUM_REQ);
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// sources, with a tx_done watchdog.
// Ports: clk, rst_n (async active-low)
//        req_valid/req_data/req_ready - per-requester byte handshake
//        tx_busy/tx_done               - transmitter status
//        tx_start/tx_data/tx_parity    - transmitter launch
//        grant_id, active, err_timeout - status
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int TIMEOUT = 4096,
    localparam int GNT_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int WD_W    = $clog2(TIMEOUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_parity,
    output logic [GNT_W-1:0]          grant_id,
    output logic                      active,
    output logic                      err_timeout
);

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_req_ready;
    logic                r_tx_start;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_tx_parity;
    logic [GNT_W-1:0]    r_grant_id;
    logic                r_active;
    logic                r_err;
    logic [WD_W-1:0]     r_wd;
    logic [GNT_W-1:0]    r_last;

    state_t              w_state_nxt;
    logic [NUM_REQ-1:0]  w_ready_nxt;
    logic                w_start_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_par_nxt;
    logic [GNT_W-1:0]    w_gid_nxt;
    logic                w_err_nxt;
    logic [WD_W-1:0]     w_wd_nxt;
    logic [GNT_W-1:0]    w_last_nxt;

    logic [GNT_W-1:0]    w_pick;
    logic                w_any;
    logic [DATA_W-1:0]   w_byte;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GNT_W)
    ) u_pick (
        .i_req        (req_valid),
        .i_last_grant (r_last),
        .o_winner     (w_pick),
        .o_any        (w_any)
    );

    assign w_byte = req_data[int'(w_pick)*DATA_W +: DATA_W];

    always_comb begin
        w_state_nxt = r_state;
        w_ready_nxt = '0;
        w_start_nxt = 1'b0;
        w_data_nxt  = r_tx_data;
        w_par_nxt   = r_tx_parity;
        w_gid_nxt   = r_grant_id;
        w_err_nxt   = 1'b0;
        w_wd_nxt    = r_wd;
        w_last_nxt  = r_last;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any && !tx_busy) begin
                    w_ready_nxt[w_pick] = 1'b1;
                    w_data_nxt          = w_byte;
                    w_par_nxt           = parity(w_byte);
                    w_gid_nxt           = w_pick;
                    w_state_nxt         = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_start_nxt = 1'b1;
                w_wd_nxt    = '0;
                w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // tx_done takes priority over an expiring watchdog.
                if (tx_done) begin
                    w_last_nxt  = r_grant_id;
                    w_state_nxt = ST_IDLE;
                end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_last_nxt  = r_grant_id;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= '0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_tx_parity <= 1'b0;
            r_grant_id  <= '0;
            r_active    <= 1'b0;
            r_err       <= 1'b0;
            r_wd        <= '0;
            // Point at the last requester so requester 0 wins first.
            r_last      <= GNT_W'(NUM_REQ - 1);
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_ready_nxt;
            r_tx_start  <= w_start_nxt;
            r_tx_data   <= w_data_nxt;
            r_tx_parity <= w_par_nxt;
            r_grant_id  <= w_gid_nxt;
            r_active    <= (w_state_nxt != ST_IDLE);
            r_err       <= w_err_nxt;
            r_wd        <= w_wd_nxt;
            r_last      <= w_last_nxt;
        end
    end

    assign req_ready   = r_req_ready;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign tx_parity   = r_tx_parity;
    assign grant_id    = r_grant_id;
    assign active      = r_active;
    assign err_timeout = r_err;

endmodule
